// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared types and encodings for the byte-wide flash sequencer.
package flash_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BAD = 2'b11;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam int RD_LAT_DEF = 3;

    // Index of the final byte of an access of the given size.
    function automatic logic [1:0] last_idx(input logic [1:0] sz);
        return sz == SZ_B ? 2'd0 : sz == SZ_H ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/flash_rr_arb.sv
// flash_rr_arb: 2-way round-robin arbiter; req[0]=fetch, req[1]=data.
module flash_rr_arb
    import flash_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            last_grant <= OWN_IF;
        else if (advance)
            last_grant <= grant[1];

    // On a tie the requester not served last wins.
    assign grant[1] = req[1] && (!req[0] || last_grant == OWN_IF);
    assign grant[0] = req[0] && (!req[1] || last_grant == OWN_D);

endmodule

// File: rtl/flash_ctrl.sv
// flash_ctrl: arbitrates fetch/data requests and sequences them as
// little-endian byte cycles on the flash port.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int AW     = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          flash_cs,
    output logic          flash_we,
    output logic          flash_re,
    output logic [AW-1:0] flash_addr,
    output logic [7:0]    flash_wdata,
    input  logic [7:0]    flash_rdata,
    output logic          busy
);

    state_t        state, state_nx;
    logic [1:0]    grant, arb_req, idx, li;
    logic          owner, we_r, err_r, bad, step;
    logic [AW-1:0] base;
    logic [31:0]   wdata_r, rbuf;
    logic [3:0]    wcnt;

    assign bad  = grant[1] && d_size == SZ_BAD;
    assign step = we_r || wcnt == 4'(RD_LAT - 1);
    // While in DONE the owner is presented alone so the arbiter records it.
    assign arb_req = state == DONE ? (owner == OWN_D ? 2'b10 : 2'b01) :
                     state == IDLE ? {d_req, if_req} : 2'b00;

    flash_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (state == DONE),
        .grant   (grant)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state == IDLE   ? (|grant ? (bad ? DONE : ACCESS) : IDLE) :
                   state == ACCESS ? (step && idx == li ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            owner   <= OWN_IF;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            base    <= '0;
            wdata_r <= '0;
            li      <= '0;
            idx     <= '0;
            wcnt    <= '0;
            rbuf    <= '0;
        end else if (state == IDLE && |grant) begin
            owner   <= grant[1];
            we_r    <= grant[1] && d_we;
            err_r   <= bad;
            base    <= grant[1] ? d_addr : if_addr;
            wdata_r <= d_wdata;
            li      <= grant[1] ? last_idx(d_size) : 2'd3;
            idx     <= '0;
            wcnt    <= '0;
            rbuf    <= '0;
        end else if (state == ACCESS) begin
            wcnt <= step ? 4'd0 : wcnt + 4'd1;
            if (step && !we_r)
                rbuf[{idx, 3'b000} +: 8] <= flash_rdata;
            if (step && idx != li)
                idx <= idx + 2'd1;
        end

    always_comb begin
        busy        = state != IDLE;
        flash_cs    = state == ACCESS;
        flash_re    = state == ACCESS && !we_r;
        flash_we    = state == ACCESS && we_r;
        flash_addr  = state == ACCESS ? base + AW'(idx) : '0;
        flash_wdata = state == ACCESS && we_r ? wdata_r[{idx, 3'b000} +: 8] : 8'h00;
        if_done     = state == DONE && owner == OWN_IF;
        d_done      = state == DONE && owner == OWN_D;
        d_err       = state == DONE && owner == OWN_D && err_r;
        if_rdata    = rbuf;
        d_rdata     = rbuf;
    end

endmodule
